multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit for the RV32I core; it drives the enable that commits the next PC into the PC register and the strobes for every other datapath element. A Moore state machine sequences each instruction through Fetch, Decode and an opcode-specific execute path. Combinational ALU and immediate decoders sit alongside the state machine. The only Mealy output is `PCWrite`, formed from branch intent and the ALU `zero` flag.

## Interface
Parameters: none.

- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `op`  in  7  instruction[6:0], from the instruction register
- `funct3`  in  3  instruction[14:12]
- `funct7b5`  in  1  instruction[30]
- `zero`  in  1  ALU result == 0, combinational, same cycle
- `PCWrite`  out  1  PC register load enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  data memory write strobe
- `IRWrite`  out  1  instruction register and OldPC load enable
- `RegWrite`  out  1  register file write strobe
- `ResultSrc`  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU A: 00 = PC, 01 = OldPC, 10 = rs1 data
- `ALUSrcB`  out  2  ALU B: 00 = rs2 data, 01 = ImmExt, 10 = constant 4
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `ImmSrc`  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- `state`  out  4  current state encoding, for debug

## Operation
State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 are unused and go to FETCH on the next edge.

Transitions:
- FETCH → DECODE.
- DECODE: op 0000011 (lw) or 0100011 (sw) → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; any other op → FETCH, with no architectural side effects.
- MEMADR: lw → MEMREAD; sw → MEMWRITE.
- MEMREAD → MEMWB.
- EXECUTER and EXECUTEI → ALUWB.
- JAL → ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.

Asserted outputs per state; any output not listed is 0:
- FETCH: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01 (branch/jump target precompute).
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.

PC enable: `PCWrite = PCUpdate | (Branch & zero)`.

ALU decode (ALUOp is an internal 2-bit signal):
- ALUOp 00 → add; ALUOp 01 → sub.
- ALUOp 10, by funct3:
  - 000: sub if op[5] & funct7b5, else add.
  - 010 → slt; 110 → or; 111 → and.
  - any other funct3 → add.

Immediate decode (pure function of op):
- lw, I-type → 00; sw → 01; beq → 10; jal → 11; others → 00.
- `ImmSrc` is valid in every state, so DECODE uses the correct immediate.

## Timing
- Reset: state = FETCH immediately, asynchronously. Outputs therefore show FETCH values while `rst` is high: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, ALUControl=000, all other outputs 0.
- State updates on the rising edge of `clk`. All outputs except `PCWrite` depend on state only. `PCWrite` also follows `zero` combinationally within BEQ.
- Cycles per instruction, counted from FETCH through the return to FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, unsupported op 2.
- Reset asserted mid-instruction: the state machine abandons the path and sits in FETCH. No write strobe may be asserted in the cycle after `rst` deasserts, except IRWrite and PCWrite.
- `op` and `funct` inputs are sampled only in DECODE, MEMADR and the execute states; they are don't-care elsewhere.
- MemWrite and RegWrite are each high for exactly one cycle per store or writeback.

## Test plan
- Reset mid-MEMREAD → `state` is 0 the same cycle; PCWrite=1, IRWrite=1, MemWrite=0, RegWrite=0.
- lw (op 0000011) → state sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01. ImmSrc=00 throughout.
- sw (op 0100011) → state sequence 0,1,2,5,0. MemWrite=1 only in state 5, with AdrSrc=1. ImmSrc=01.
- R-type: sub (funct3 000, funct7b5 1) gives ALUControl=001 in EXECUTER; slt gives 101; and gives 010; or gives 011. I-type addi with funct7b5=1 gives ALUControl=000.
- beq with zero=1 in state 9 → PCWrite=1. Same instruction with zero=0 → PCWrite=0. Both return to FETCH on the next edge.
- jal → state sequence 0,1,10,8,0. PCWrite=1 in states 0 and 10. ImmSrc=11. Separately, op 1111111 in DECODE → FETCH next cycle with no MemWrite and no RegWrite.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: Moore sequencer with registered strobes,
// plus combinational ALU-control and immediate-select decoders.
// PCWrite is the only output that also depends on a live input (zero).
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore strobes for a given state; anything not set stays 0.
  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      StDecode: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      StMemRead:  c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      StMemWrite: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      StExecuteR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      StExecuteI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      StAluWb:    c.reg_write = 1'b1;
      StBeq: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      StJal: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  // Next-state sequencing; unused encodings fall back to FETCH.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExecuteR;
          OpIType:    state_d = StExecuteI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          default:    state_d = StFetch;
        endcase
      end
      // op[5] separates sw (1) from lw (0).
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // State and strobes registered together so strobes always match the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      ctrl_q  <= ctrl_for(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  // ALU operation from ALUOp and instruction fields.
  always_comb begin
    ALUControl = 3'b000;
    case (ctrl_q.alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format depends only on op so DECODE sees the right immediate.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpSw:    ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Output drive; PCWrite mixes in the live zero flag for branches.
  always_comb begin
    PCWrite   = ctrl_q.pc_update | (ctrl_q.branch & zero);
    AdrSrc    = ctrl_q.adr_src;
    MemWrite  = ctrl_q.mem_write;
    IRWrite   = ctrl_q.ir_write;
    RegWrite  = ctrl_q.reg_write;
    ResultSrc = ctrl_q.result_src;
    ALUSrcA   = ctrl_q.alu_src_a;
    ALUSrcB   = ctrl_q.alu_src_b;
    state     = state_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares strobes against hand-derived values.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int checks_q = 0;
  int errors_q = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_q++;
    if (obs !== exp) begin
      errors_q++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one instruction from FETCH; seq holds the expected states in order.
  task automatic run_instr(input string name, input logic [6:0] op_v, input logic [2:0] f3,
                           input logic f7, input int n, input int seq [6],
                           input logic [1:0] imm_exp, input logic [2:0] alu_exp);
    int st;
    op       = op_v;
    funct3   = f3;
    funct7b5 = f7;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      st   = seq[i];
      zero = 1'($urandom_range(0, 1));
      #1;
      check_eq({name, " state"}, 32'(state), 32'(st));
      check_eq({name, " RegWrite"}, 32'(RegWrite), 32'(st == 4 || st == 8));
      check_eq({name, " MemWrite"}, 32'(MemWrite), 32'(st == 5));
      check_eq({name, " ImmSrc"}, 32'(ImmSrc), 32'(imm_exp));
      if (st == 6 || st == 7) check_eq({name, " ALUControl"}, 32'(ALUControl), 32'(alu_exp));
      else check_eq({name, " ALUControl"}, 32'(ALUControl), (st == 9) ? 32'd1 : 32'd0);
      if (st == 4) check_eq({name, " ResultSrc"}, 32'(ResultSrc), 32'd1);
      if (st == 5) check_eq({name, " AdrSrc"}, 32'(AdrSrc), 32'd1);
      if (st == 9) begin
        zero = 1'b1;
        #1;
        check_eq({name, " PCWrite z1"}, 32'(PCWrite), 32'd1);
        zero = 1'b0;
        #1;
        check_eq({name, " PCWrite z0"}, 32'(PCWrite), 32'd0);
      end else begin
        check_eq({name, " PCWrite"}, 32'(PCWrite), 32'(st == 0 || st == 10));
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    op       = 7'b0;
    funct3   = 3'b0;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    #3;
    check_eq("rst state", 32'(state), 32'd0);
    check_eq("rst IRWrite", 32'(IRWrite), 32'd1);
    check_eq("rst PCWrite", 32'(PCWrite), 32'd1);
    check_eq("rst ALUSrcB", 32'(ALUSrcB), 32'd2);
    check_eq("rst ResultSrc", 32'(ResultSrc), 32'd2);
    check_eq("rst ALUControl", 32'(ALUControl), 32'd0);
    check_eq("rst others", {26'd0, AdrSrc, MemWrite, RegWrite, ALUSrcA, 1'b0}, 32'd0);
    step();
    rst = 1'b0;

    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 6, '{0, 1, 2, 3, 4, 0}, 2'b00, 3'b000);
    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 5, '{0, 1, 2, 5, 0, 0}, 2'b01, 3'b000);
    run_instr("sub", 7'b0110011, 3'b000, 1'b1, 5, '{0, 1, 6, 8, 0, 0}, 2'b00, 3'b001);
    run_instr("slt", 7'b0110011, 3'b010, 1'b0, 5, '{0, 1, 6, 8, 0, 0}, 2'b00, 3'b101);
    run_instr("and", 7'b0110011, 3'b111, 1'b0, 5, '{0, 1, 6, 8, 0, 0}, 2'b00, 3'b010);
    run_instr("or", 7'b0110011, 3'b110, 1'b0, 5, '{0, 1, 6, 8, 0, 0}, 2'b00, 3'b011);
    run_instr("addi", 7'b0010011, 3'b000, 1'b1, 5, '{0, 1, 7, 8, 0, 0}, 2'b00, 3'b000);
    run_instr("beq", 7'b1100011, 3'b000, 1'b0, 4, '{0, 1, 9, 0, 0, 0}, 2'b10, 3'b000);
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 5, '{0, 1, 10, 8, 0, 0}, 2'b11, 3'b000);
    run_instr("badop", 7'b1111111, 3'b000, 1'b0, 3, '{0, 1, 0, 0, 0, 0}, 2'b00, 3'b000);

    // Abandon a load in MEMREAD with an asynchronous reset.
    op = 7'b0000011;
    step();
    step();
    step();
    check_eq("pre-reset state", 32'(state), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst state", 32'(state), 32'd0);
    check_eq("midrst PCWrite", 32'(PCWrite), 32'd1);
    check_eq("midrst IRWrite", 32'(IRWrite), 32'd1);
    check_eq("midrst MemWrite", 32'(MemWrite), 32'd0);
    check_eq("midrst RegWrite", 32'(RegWrite), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("postrst state", 32'(state), 32'd0);
    check_eq("postrst writes", {30'd0, MemWrite, RegWrite}, 32'd0);
    step();
    check_eq("postrst decode", 32'(state), 32'd1);
    step();
    check_eq("postrst memadr", 32'(state), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
